// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: shared types and constants for the data-memory load/store unit.
//   state_t         - LSU sequencing states
//   F3_*            - RV32 load/store width codes (funct3)
//   ERR_*           - err_cause encodings
//   access_bytes()  - access size in bytes for a funct3 width code
package dmem_lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_WAIT,
    LD_DATA,
    ST_WR,
    ERR
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_FUNCT3   = 2'b11;

  // Low two funct3 bits carry the width for both signed and unsigned forms.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   access_bytes = 3'd1;
      2'b01:   access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: pipeline-side request/response bundle of the load/store unit.
//   req_*        - one load/store request, valid/ready handshake
//   resp_*       - load result pulse with echoed destination tag
//   store_done   - store completion pulse
//   err_*        - rejected-request pulse with cause and offending address
// Modports: master = memory stage (issues requests), slave = LSU.
interface dmem_lsu_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            req_valid;
  logic            req_ready;
  logic            req_is_store;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [RD_W-1:0] req_rd;

  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic [RD_W-1:0] resp_rd;
  logic            store_done;

  logic            err_valid;
  logic [1:0]      err_cause;
  logic [XLEN-1:0] err_addr;

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready, resp_valid, resp_rdata, resp_rd, store_done,
           err_valid, err_cause, err_addr
  );

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready, resp_valid, resp_rdata, resp_rd, store_done,
           err_valid, err_cause, err_addr
  );
endinterface

// File: rtl/dmem_load_align.sv
// dmem_load_align: combinational load-data extractor.
//   rdata   in  XLEN  full memory word
//   offset  in  2     byte offset of the access within the word
//   funct3  in  3     load width code (LB/LH/LW/LBU/LHU)
//   data    out XLEN  right-justified, sign- or zero-extended result
module dmem_load_align
  import dmem_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_HU:   data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: single-outstanding load/store initiator for the data memory.
//   clk, rst      - clock (rising edge), asynchronous active-high reset
//   bus (slave)   - request/response bundle from the memory stage
//   dmem_re/raddr/rdata          - synchronous read port, 1-cycle latency
//   dmem_we/waddr/wdata/wstrb    - byte-strobed write port
// Requests are checked (funct3 > misalignment > range) when accepted; bad
// requests produce an err pulse and never touch memory.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DMEM_BYTES = 4096,
  parameter int RD_W       = 5
) (
  input  logic            clk,
  input  logic            rst,
  dmem_lsu_if.slave       bus,
  output logic            dmem_re,
  output logic [XLEN-1:0] dmem_raddr,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_waddr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb
);

  state_t          state;

  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic [RD_W-1:0] resp_rd;
  logic            store_done;
  logic            err_valid;
  logic [1:0]      err_cause;
  logic [XLEN-1:0] err_addr;

  // Load context captured at accept, used when the read data returns.
  logic [1:0]      ld_off;
  logic [2:0]      ld_f3;
  logic [RD_W-1:0] ld_rd;

  logic [2:0]      nbytes;
  logic            bad_f3;
  logic            misalign;
  logic            out_range;
  logic            bad;
  logic [1:0]      cause;
  logic [XLEN-1:0] st_data;
  logic [3:0]      st_strb;
  logic [XLEN-1:0] ld_data;

  // Held low during reset so no request can be taken while rst is asserted.
  assign bus.req_ready  = (state == IDLE) && !rst;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = resp_rdata;
  assign bus.resp_rd    = resp_rd;
  assign bus.store_done = store_done;
  assign bus.err_valid  = err_valid;
  assign bus.err_cause  = err_cause;
  assign bus.err_addr   = err_addr;

  always_comb begin
    nbytes = access_bytes(bus.req_funct3);
    if (bus.req_is_store)
      bad_f3 = !(bus.req_funct3 == F3_B || bus.req_funct3 == F3_H ||
                 bus.req_funct3 == F3_W);
    else
      bad_f3 = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
    misalign  = (nbytes == 3'd2 && bus.req_addr[0]) ||
                (nbytes == 3'd4 && bus.req_addr[1:0] != 2'b00);
    out_range = bus.req_addr > (XLEN'(DMEM_BYTES) - XLEN'(nbytes));
    bad       = bad_f3 || misalign || out_range;
    if (bad_f3)        cause = ERR_FUNCT3;
    else if (misalign) cause = ERR_MISALIGN;
    else               cause = ERR_RANGE;
  end

  // Store lane replication and strobes.
  always_comb begin
    case (bus.req_funct3[1:0])
      2'b00: begin
        st_data = {(XLEN/8){bus.req_wdata[7:0]}};
        st_strb = 4'b0001 << bus.req_addr[1:0];
      end
      2'b01: begin
        st_data = {(XLEN/16){bus.req_wdata[15:0]}};
        st_strb = 4'b0011 << {bus.req_addr[1], 1'b0};
      end
      default: begin
        st_data = bus.req_wdata;
        st_strb = 4'b1111;
      end
    endcase
  end

  dmem_load_align #(.XLEN(XLEN)) u_align (
    .rdata  (dmem_rdata),
    .offset (ld_off),
    .funct3 (ld_f3),
    .data   (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dmem_re    <= 1'b0;
      dmem_raddr <= '0;
      dmem_we    <= 1'b0;
      dmem_waddr <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_rd    <= '0;
      store_done <= 1'b0;
      err_valid  <= 1'b0;
      err_cause  <= '0;
      err_addr   <= '0;
      ld_off     <= '0;
      ld_f3      <= '0;
      ld_rd      <= '0;
    end else begin
      resp_valid <= 1'b0;
      store_done <= 1'b0;
      err_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (bad) begin
              err_valid <= 1'b1;
              err_cause <= cause;
              err_addr  <= bus.req_addr;
              state     <= ERR;
            end else if (bus.req_is_store) begin
              dmem_we    <= 1'b1;
              dmem_waddr <= bus.req_addr;
              dmem_wdata <= st_data;
              dmem_wstrb <= st_strb;
              state      <= ST_WR;
            end else begin
              dmem_re    <= 1'b1;
              dmem_raddr <= bus.req_addr;
              ld_off     <= bus.req_addr[1:0];
              ld_f3      <= bus.req_funct3;
              ld_rd      <= bus.req_rd;
              state      <= LD_WAIT;
            end
          end
        end
        LD_WAIT: begin
          dmem_re <= 1'b0;
          state   <= LD_DATA;
        end
        LD_DATA: begin
          resp_valid <= 1'b1;
          resp_rdata <= ld_data;
          resp_rd    <= ld_rd;
          state      <= IDLE;
        end
        ST_WR: begin
          dmem_we    <= 1'b0;
          dmem_wstrb <= '0;
          store_done <= 1'b1;
          state      <= IDLE;
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: scoreboard bench for dmem_lsu with a behavioural data memory.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  localparam int K_LD  = 0;
  localparam int K_ST  = 1;
  localparam int K_ERR = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dmem_re, dmem_we;
  logic [31:0] dmem_raddr, dmem_rdata, dmem_waddr, dmem_wdata;
  logic [3:0]  dmem_wstrb;

  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  typedef struct {
    logic [2:0]  kind;   // {err_valid, store_done, resp_valid}
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [1:0]  cause;
    logic [3:0]  strb;
    int unsigned cyc;
  } exp_t;

  exp_t rd_q[$];
  exp_t wr_q[$];
  exp_t out_q[$];

  logic [7:0] mem [0:4095];

  dmem_lsu_if #(.XLEN(32), .RD_W(5)) bus ();

  dmem_lsu #(.XLEN(32), .DMEM_BYTES(4096), .RD_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dmem_re    (dmem_re),
    .dmem_raddr (dmem_raddr),
    .dmem_rdata (dmem_rdata),
    .dmem_we    (dmem_we),
    .dmem_waddr (dmem_waddr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous byte-strobed memory, 1-cycle read latency.
  always @(posedge clk) begin
    if (dmem_re)
      dmem_rdata <= {mem[{dmem_raddr[11:2], 2'b11}], mem[{dmem_raddr[11:2], 2'b10}],
                     mem[{dmem_raddr[11:2], 2'b01}], mem[{dmem_raddr[11:2], 2'b00}]};
    if (dmem_we) begin
      for (int b = 0; b < 4; b++)
        if (dmem_wstrb[b]) mem[{dmem_waddr[11:2], 2'(b)}] <= dmem_wdata[8*b +: 8];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: pops expectations as the DUT produces memory accesses and pulses.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (dmem_re && dmem_we) check_eq("re_we_overlap", {31'b0, dmem_we}, 32'd0);
      if (dmem_re) begin
        if (rd_q.size() == 0) check_eq("re_spurious", {31'b0, dmem_re}, 32'd0);
        else begin
          e = rd_q.pop_front();
          check_eq("raddr", dmem_raddr, e.addr);
          check_eq("re_cycle", cyc, e.cyc);
        end
      end
      if (dmem_we) begin
        if (wr_q.size() == 0) check_eq("we_spurious", {31'b0, dmem_we}, 32'd0);
        else begin
          e = wr_q.pop_front();
          check_eq("waddr", dmem_waddr, e.addr);
          check_eq("wdata", dmem_wdata, e.data);
          check_eq("wstrb", {28'b0, dmem_wstrb}, {28'b0, e.strb});
          check_eq("we_cycle", cyc, e.cyc);
        end
      end
      if (bus.resp_valid || bus.store_done || bus.err_valid) begin
        if (out_q.size() == 0)
          check_eq("out_spurious", {29'b0, bus.err_valid, bus.store_done, bus.resp_valid}, 32'd0);
        else begin
          e = out_q.pop_front();
          check_eq("out_kind", {29'b0, bus.err_valid, bus.store_done, bus.resp_valid},
                   {29'b0, e.kind});
          check_eq("out_cycle", cyc, e.cyc);
          if (e.kind == 3'b001) begin
            check_eq("resp_rdata", bus.resp_rdata, e.data);
            check_eq("resp_rd", {27'b0, bus.resp_rd}, {27'b0, e.rd});
          end else if (e.kind == 3'b100) begin
            check_eq("err_cause", {30'b0, bus.err_cause}, {30'b0, e.cause});
            check_eq("err_addr", bus.err_addr, e.addr);
          end
        end
      end
    end
  end

  // Drive one request and hold it until accepted; pushes expectations at accept.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd, input int kind,
                        input logic [31:0] exp_data, input logic [3:0] exp_strb,
                        input logic [1:0] exp_cause, output int waits);
    exp_t e;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_rd       = rd;
    waits = 0;
    while (!bus.req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.req_ready) check_eq("ready_timeout", {31'b0, bus.req_ready}, 32'd1);
    e.addr = addr; e.data = exp_data; e.rd = rd; e.cause = exp_cause; e.strb = exp_strb;
    if (kind == K_LD) begin
      e.cyc = cyc + 1; rd_q.push_back(e);
      e.kind = 3'b001; e.cyc = cyc + 3; out_q.push_back(e);
    end else if (kind == K_ST) begin
      e.cyc = cyc + 1; wr_q.push_back(e);
      e.kind = 3'b010; e.cyc = cyc + 2; out_q.push_back(e);
    end else begin
      e.kind = 3'b100; e.cyc = cyc + 1; out_q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    {mem[32'h103], mem[32'h102], mem[32'h101], mem[32'h100]} = 32'h8081F2F3;
    bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0;

    repeat (2) @(negedge clk);
    check_eq("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    check_eq("rst_re", {31'b0, dmem_re}, 32'd0);
    check_eq("rst_we", {31'b0, dmem_we}, 32'd0);
    check_eq("rst_resp_rdata", bus.resp_rdata, 32'd0);
    rst = 1'b0;
    #1 check_eq("ready_after_rst", {31'b0, bus.req_ready}, 32'd1);

    // Loads of 0x8081F2F3 at 0x100
    do_req(0, F3_B,  32'h101, 0, 5'd1, K_LD,  32'hFFFFFFF2, 0, 0, w); idle(1);
    do_req(0, F3_BU, 32'h103, 0, 5'd2, K_LD,  32'h00000080, 0, 0, w); idle(1);
    do_req(0, F3_H,  32'h102, 0, 5'd3, K_LD,  32'hFFFF8081, 0, 0, w); idle(1);
    do_req(0, F3_HU, 32'h100, 0, 5'd4, K_LD,  32'h0000F2F3, 0, 0, w); idle(1);
    do_req(0, F3_W,  32'h100, 0, 5'd7, K_LD,  32'h8081F2F3, 0, 0, w); idle(1);

    // Stores and readback of merged lanes
    do_req(1, F3_B, 32'h105, 32'h000000AB, 0, K_ST, 32'hABABABAB, 4'b0010, 0, w); idle(1);
    do_req(1, F3_H, 32'h106, 32'h00001234, 0, K_ST, 32'h12341234, 4'b1100, 0, w); idle(1);
    do_req(0, F3_W, 32'h104, 0, 5'd9, K_LD, 32'h1234AB00, 0, 0, w); idle(1);

    // Rejections and range boundary
    do_req(0, F3_W,   32'h102,  0, 5'd1, K_ERR, 0, 0, ERR_MISALIGN, w); idle(1);
    do_req(1, F3_W,   32'hFFC,  32'hDEADBEEF, 0, K_ST, 32'hDEADBEEF, 4'b1111, 0, w); idle(1);
    do_req(0, F3_W,   32'hFFC,  0, 5'd11, K_LD, 32'hDEADBEEF, 0, 0, w); idle(1);
    do_req(1, F3_W,   32'h1000, 32'h1, 0, K_ERR, 0, 0, ERR_RANGE, w); idle(1);
    do_req(0, 3'b110, 32'h100,  0, 5'd1, K_ERR, 0, 0, ERR_FUNCT3, w); idle(1);
    do_req(1, 3'b011, 32'h1001, 0, 0,    K_ERR, 0, 0, ERR_FUNCT3, w); idle(1);
    do_req(0, F3_H,   32'h1001, 0, 5'd1, K_ERR, 0, 0, ERR_MISALIGN, w); idle(1);
    do_req(0, F3_B,   32'h1000, 0, 5'd1, K_ERR, 0, 0, ERR_RANGE, w); idle(1);
    do_req(0, F3_BU,  32'hFFF,  0, 5'd12, K_LD, 32'h000000DE, 0, 0, w); idle(1);
    do_req(0, F3_HU,  32'hFFE,  0, 5'd13, K_LD, 32'h0000DEAD, 0, 0, w); idle(1);

    // Back-to-back with req_valid held high
    do_req(0, F3_W, 32'h100, 0, 5'd7, K_LD, 32'h8081F2F3, 0, 0, w);
    do_req(0, F3_B, 32'h101, 0, 5'd8, K_LD, 32'hFFFFFFF2, 0, 0, w);
    check_eq("b2b_wait_cycles", w, 32'd2);
    do_req(1, F3_B, 32'h104, 32'h55, 0, K_ST, 32'h55555555, 4'b0001, 0, w);
    check_eq("b2b_store_wait", w, 32'd2);
    idle(1);

    // Reset in the middle of a load
    do_req(0, F3_W, 32'h100, 0, 5'd5, K_LD, 32'h8081F2F3, 0, 0, w);
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    out_q.delete();
    #1;
    check_eq("midrst_re", {31'b0, dmem_re}, 32'd0);
    check_eq("midrst_ready", {31'b0, bus.req_ready}, 32'd0);
    check_eq("midrst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check_eq("midrst_raddr", dmem_raddr, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check_eq("ready_after_midrst", {31'b0, bus.req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    do_req(0, F3_W, 32'h100, 0, 5'd7, K_LD, 32'h8081F2F3, 0, 0, w); idle(1);

    idle(6);
    check_eq("rd_q_drained",  rd_q.size(),  32'd0);
    check_eq("wr_q_drained",  wr_q.size(),  32'd0);
    check_eq("out_q_drained", out_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
